// File: rtl/tx_shifter.sv
// Serial transmitter: a holding register feeds a shift register that sends
// start, eight data bits LSB first and stop, each bit lasting OVS en ticks.
module tx_shifter #(
    parameter int OVS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       tbr,
    output logic       busy,
    output logic [1:0] state_dbg
);

    localparam int TW = $clog2(OVS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic [7:0]      hold_data;
    logic [7:0]      shift;
    logic            hold_full;
    logic            hold_armed;
    logic [TW-1:0]   tick_cnt;
    logic [2:0]      bit_cnt;
    logic            load_ok;
    logic            launch;
    logic            bit_end;

    // Handshake: load is a single-cycle strobe, honoured only while tbr=1;
    // a strobe seen while tbr=0 is dropped without any effect.
    assign load_ok   = load & ~hold_full;
    assign launch    = (state == IDLE) & hold_full & hold_armed;
    assign bit_end   = en & (tick_cnt == TW'(OVS - 1));
    assign tbr       = ~hold_full;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            hold_data  <= 8'h00;
            hold_full  <= 1'b0;
            hold_armed <= 1'b0;
            shift      <= 8'h00;
            tick_cnt   <= '0;
            bit_cnt    <= 3'd0;
        end else begin
            // A byte loaded while idle waits one extra cycle before launch, so
            // launch latency is a fixed two edges; one loaded mid-frame is armed at once.
            if (load_ok) begin
                hold_data  <= data_in;
                hold_full  <= 1'b1;
                hold_armed <= (state != IDLE);
            end else if (launch) begin
                hold_full  <= 1'b0;
                hold_armed <= 1'b0;
            end else begin
                hold_armed <= hold_full;
            end

            if (state != IDLE && en) begin
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    tick_cnt <= '0;
                    bit_cnt  <= 3'd0;
                    if (launch) begin
                        shift <= hold_data;
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        tx    <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_shifter.sv
// Directed bench for tx_shifter (OVS=16): reset, framing, back-to-back,
// ignored loads, mid-frame reset and en stalls.
module tb_tx_shifter;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx;
    logic       tbr;
    logic       busy;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int en_period = 1;
    int en_ph = 0;

    logic tx_rec   [0:699];
    logic busy_rec [0:699];
    logic tbr_rec  [0:699];

    tx_shifter #(.OVS(16)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .data_in(data_in),
        .tx(tx), .tbr(tbr), .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // One clock: en follows the pulse pattern when en_period>1; load self-clears.
    task step();
        if (en_period > 1) begin
            en = (en_ph == 0);
            en_ph = (en_ph + 1) % en_period;
        end
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task load_byte(input logic [7:0] d);
        load = 1'b1;
        data_in = d;
        step();
    endtask

    // Samples mid-bit with en held high; pos is the cycle index within the
    // frame already reached, or negative to wait for the frame to begin.
    task automatic capture(input int pos, output logic [7:0] d, output logic st,
                           output logic sp, output logic to);
        int idx;
        int n;
        to = 1'b0; d = 8'h00; st = 1'b0; sp = 1'b0; idx = pos;
        if (pos < 0) begin
            n = 0;
            while (busy !== 1'b1 && n < 100) begin step(); n++; end
            if (busy !== 1'b1) begin to = 1'b1; return; end
            idx = 0;
        end
        while (idx < 8) begin step(); idx++; end
        st = tx;
        for (int k = 0; k < 8; k++) begin
            while (idx < 16 * (k + 1) + 8) begin step(); idx++; end
            d[k] = tx;
        end
        while (idx < 152) begin step(); idx++; end
        sp = tx;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin step(); n++; end
        if (busy !== 1'b0) to = 1'b1;
    endtask

    task test_reset();
        rst = 1'b1;
        load = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (tbr !== 1'b1) begin errors++; $display("FAIL reset_tbr got %b want 1", tbr); end
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", state_dbg, S_IDLE); end
    endtask

    task test_single();
        logic [9:0] frame;
        int nbusy;
        frame = {1'b1, 8'hA5, 1'b0};
        en_period = 4;
        en_ph = 2;
        load_byte(8'hA5);
        checks++; if (tbr !== 1'b0) begin errors++; $display("FAIL single_tbr_n got %b want 0", tbr); end
        step();
        checks++; if (tx !== 1'b1 || tbr !== 1'b0) begin errors++; $display("FAIL single_n1 got tx=%b tbr=%b want tx=1 tbr=0", tx, tbr); end
        step();
        checks++; if (tbr !== 1'b1) begin errors++; $display("FAIL single_tbr_n2 got %b want 1", tbr); end
        for (int i = 0; i < 700; i++) begin
            tx_rec[i] = tx;
            busy_rec[i] = busy;
            step();
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (tx_rec[64 * k] !== frame[k] || tx_rec[64 * k + 63] !== frame[k]) begin
                errors++;
                $display("FAIL single_bit%0d got %b..%b want %b", k, tx_rec[64 * k], tx_rec[64 * k + 63], frame[k]);
            end
        end
        for (int k = 1; k < 10; k++) begin
            if (frame[k] != frame[k - 1]) begin
                checks++;
                if (tx_rec[64 * k - 1] !== frame[k - 1]) begin
                    errors++;
                    $display("FAIL single_edge%0d got %b want %b", k, tx_rec[64 * k - 1], frame[k - 1]);
                end
            end
        end
        nbusy = 0;
        for (int i = 0; i < 700; i++) if (busy_rec[i] === 1'b1) nbusy++;
        checks++; if (nbusy != 640) begin errors++; $display("FAIL single_busy_len got %0d want 640", nbusy); end
        checks++; if (busy_rec[639] !== 1'b1 || busy_rec[640] !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b%b want 10", busy_rec[639], busy_rec[640]); end
        en_period = 1;
        en = 1'b1;
    endtask

    task test_back_to_back();
        int bad_tbr;
        int idle_cnt;
        en = 1'b1;
        load_byte(8'h00);
        step();
        step();
        for (int i = 0; i < 330; i++) begin
            tx_rec[i] = tx;
            busy_rec[i] = busy;
            tbr_rec[i] = tbr;
            if (i == 19) begin
                load = 1'b1;
                data_in = 8'hFF;
            end
            step();
        end
        checks++; if (tx_rec[0] !== 1'b0 || tx_rec[143] !== 1'b0) begin errors++; $display("FAIL b2b_f1_data got %b%b want 00", tx_rec[0], tx_rec[143]); end
        checks++; if (tx_rec[144] !== 1'b1 || tx_rec[159] !== 1'b1) begin errors++; $display("FAIL b2b_f1_stop got %b%b want 11", tx_rec[144], tx_rec[159]); end
        checks++; if (tx_rec[160] !== 1'b1 || busy_rec[160] !== 1'b0) begin errors++; $display("FAIL b2b_gap got tx=%b busy=%b want tx=1 busy=0", tx_rec[160], busy_rec[160]); end
        checks++; if (tx_rec[161] !== 1'b0 || busy_rec[161] !== 1'b1) begin errors++; $display("FAIL b2b_f2_start got tx=%b busy=%b want tx=0 busy=1", tx_rec[161], busy_rec[161]); end
        checks++; if (tx_rec[176] !== 1'b0 || tx_rec[177] !== 1'b1) begin errors++; $display("FAIL b2b_f2_bit0 got %b%b want 01", tx_rec[176], tx_rec[177]); end
        checks++; if (tx_rec[320] !== 1'b1 || busy_rec[320] !== 1'b1 || busy_rec[321] !== 1'b0) begin errors++; $display("FAIL b2b_f2_end got tx=%b busy=%b%b want 1 10", tx_rec[320], busy_rec[320], busy_rec[321]); end
        idle_cnt = 0;
        for (int i = 1; i < 300; i++) if (busy_rec[i] === 1'b0) idle_cnt++;
        checks++; if (idle_cnt != 1) begin errors++; $display("FAIL b2b_idle_clocks got %0d want 1", idle_cnt); end
        bad_tbr = 0;
        for (int i = 20; i <= 160; i++) if (tbr_rec[i] !== 1'b0) bad_tbr++;
        checks++; if (bad_tbr != 0) begin errors++; $display("FAIL b2b_tbr_held got %0d high cycles want 0", bad_tbr); end
        checks++; if (tbr_rec[161] !== 1'b1) begin errors++; $display("FAIL b2b_tbr_release got %b want 1", tbr_rec[161]); end
        for (int i = 0; i < 20; i++) step();
    endtask

    task test_ignored_load();
        logic [7:0] d;
        logic st, sp, to;
        int late_busy;
        en = 1'b1;
        load_byte(8'h0F);
        step();
        step();
        load_byte(8'h81);
        checks++; if (tbr !== 1'b0) begin errors++; $display("FAIL ign_accept got tbr=%b want 0", tbr); end
        load_byte(8'h3C);
        checks++; if (tbr !== 1'b0) begin errors++; $display("FAIL ign_tbr got %b want 0", tbr); end
        capture(2, d, st, sp, to);
        checks++; if (to || d !== 8'h0F || st !== 1'b0 || sp !== 1'b1) begin errors++; $display("FAIL ign_frame1 got %h st=%b sp=%b to=%b want 0f 0 1 0", d, st, sp, to); end
        capture(-1, d, st, sp, to);
        checks++; if (to || d !== 8'h81 || st !== 1'b0 || sp !== 1'b1) begin errors++; $display("FAIL ign_frame2 got %h st=%b sp=%b to=%b want 81 0 1 0", d, st, sp, to); end
        late_busy = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (busy !== 1'b0 || tx !== 1'b1) late_busy++;
        end
        checks++; if (late_busy != 0) begin errors++; $display("FAIL ign_no_third got %0d active cycles want 0", late_busy); end
    endtask

    task test_reset_mid();
        logic [7:0] d;
        logic st, sp, to;
        en = 1'b1;
        load_byte(8'h00);
        step();
        step();
        for (int i = 0; i < 88; i++) step();
        checks++; if (tx !== 1'b0 || state_dbg !== S_DATA) begin errors++; $display("FAIL rmid_pre got tx=%b state=%0d want 0 %0d", tx, state_dbg, S_DATA); end
        rst = 1'b1;
        load = 1'b1;
        data_in = 8'hAA;
        step();
        rst = 1'b0;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rmid_tx got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        checks++; if (tbr !== 1'b1) begin errors++; $display("FAIL rmid_tbr got %b want 1", tbr); end
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL rmid_state got %0d want %0d", state_dbg, S_IDLE); end
        load_byte(8'h55);
        checks++; if (tbr !== 1'b0) begin errors++; $display("FAIL rmid_first_load got tbr=%b want 0", tbr); end
        capture(-1, d, st, sp, to);
        checks++; if (to || d !== 8'h55 || st !== 1'b0 || sp !== 1'b1) begin errors++; $display("FAIL rmid_frame got %h st=%b sp=%b to=%b want 55 0 1 0", d, st, sp, to); end
    endtask

    task test_stall();
        int bad;
        int n;
        en = 1'b1;
        load_byte(8'hFF);
        step();
        step();
        for (int i = 0; i < 5; i++) step();
        en = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx !== 1'b0 || state_dbg !== S_START) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
        en = 1'b1;
        for (int i = 0; i < 10; i++) step();
        checks++; if (tx !== 1'b0 || state_dbg !== S_START) begin errors++; $display("FAIL stall_tick15 got tx=%b state=%0d want 0 %0d", tx, state_dbg, S_START); end
        step();
        checks++; if (tx !== 1'b1 || state_dbg !== S_DATA) begin errors++; $display("FAIL stall_tick16 got tx=%b state=%0d want 1 %0d", tx, state_dbg, S_DATA); end
        n = 0;
        while (busy !== 1'b0 && n < 400) begin step(); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_finish got busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored_load();
        test_reset_mid();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_shifter.md
TX_SHIFTER -- requirements
Module: tx_shifter

Interface
REQ-001 Parameter OVS, default 16: number of `en` ticks per serial bit time; legal range 2..256.
REQ-002 clk  input  1  single clock for the block; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 en  input  1  oversample tick, OVS ticks per bit time; may be held high continuously.
REQ-005 load  input  1  one-cycle write strobe; captures data_in into the holding register when tbr=1.
REQ-006 data_in  input  8  byte to transmit; sampled only on an accepted load.
REQ-007 tx  output  1  registered serial line; idles high.
REQ-008 tbr  output  1  transmit buffer ready; high when the holding register is empty.
REQ-009 busy  output  1  registered; high while a frame (start, data or stop bit) is on the line.

Function
REQ-010 Frame format: 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1); each bit is exactly OVS `en` ticks.
REQ-011 Buffering: one holding register plus one shift register, so a second byte can be accepted while a frame is in flight.
REQ-012 A load with tbr=1 sets the holding register; tbr is 0 from the next edge.
REQ-013 A load with tbr=0 is ignored; the holding register and data_in have no effect.
REQ-014 FSM states: IDLE, START, DATA, STOP; reset state is IDLE.
REQ-015 IDLE: tx=1 and busy=0.
REQ-016 IDLE with a full holding register: on the next edge, copy holding to shift, clear holding (tbr=1), clear the tick and bit counters, enter START (tx=0, busy=1).
REQ-017 Latency: load accepted at edge N gives tx=0 and busy=1 after edge N+2, and tbr=1 after edge N+2.
REQ-018 Tick counter: 0..OVS-1, advances only on clock cycles with en=1; a bit ends on the en cycle where the count is OVS-1, and the count wraps to 0.
REQ-019 START: at bit end, enter DATA; tx = shift[0].
REQ-020 DATA: at each bit end, shift right and increment the 3-bit bit counter; after bit index 7 ends, enter STOP with tx=1.
REQ-021 STOP: at bit end, enter IDLE with busy=0; tx stays 1.
REQ-022 Back-to-back frames: if holding is full when STOP ends, exactly one clock of IDLE (tx=1) precedes the next START.
REQ-023 A load accepted in the same cycle that STOP ends is held, and follows the back-to-back rule.
REQ-024 en=0 freezes all counters and tx; the FSM changes state only on en cycles, except the IDLE->START transfer, which ignores en.
REQ-025 With en held high: bit time = OVS clocks and frame = 10*OVS clocks.
REQ-026 tx, busy and tbr never glitch; all three are driven from flops or decoded from registered state only.

Reset
REQ-027 rst=1 at an edge: state=IDLE, tx=1, busy=0, tbr=1, holding cleared, tick and bit counters 0; any frame in progress is aborted.
REQ-028 load asserted in the same cycle as rst=1 is ignored.
REQ-029 After rst deasserts, the block accepts a load on the first cycle.

Verification
REQ-030 Reset sequence: rst high for 2 clocks, then low -> tx=1, busy=0, tbr=1 on the first post-reset cycle.
REQ-031 Single byte 0xA5, OVS=16, en pulsing once every 4 clocks -> line carries 0,1,0,1,0,0,1,0,1,1, each bit exactly 64 clocks; busy spans 640 clocks; tbr=1 two edges after the load.
REQ-032 Back-to-back 0x00 then 0xFF, second load while busy, en held high -> two frames separated by exactly 1 idle clock; tbr stays 0 from the second load until the second START.
REQ-033 Load 0x3C while tbr=0 (holding already full with 0x81) -> only 0x81 and the first byte are transmitted; 0x3C never appears on tx.
REQ-034 Reset mid-frame during DATA bit 4 -> tx=1 on the next cycle, busy=0, tbr=1; a new load of 0x55 then gives a clean full frame.
REQ-035 en stalled low for 100 clocks mid-START -> tx stays 0 for the whole stall; the start bit still lasts exactly OVS ticks in total.
